// File: rtl/demux1x4_4bits_reg.sv
// Registered 1-to-4 nibble distributor: nibbles fill four shadow slots (auto pointer or
// explicit select) and whole frames are committed atomically to the output registers.
module demux1x4_4bits_reg #(
    parameter int P_W   = 4,
    parameter int P_SEL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [P_W-1:0]   ent,
    input  logic [P_SEL-1:0] sel,
    input  logic             auto_mode,
    input  logic             in_valid,
    input  logic             commit,
    input  logic             clear,
    output logic             in_ready,
    output logic [P_W-1:0]   out0,
    output logic [P_W-1:0]   out1,
    output logic [P_W-1:0]   out2,
    output logic [P_W-1:0]   out3,
    output logic [P_SEL-1:0] ptr,
    output logic             frame_done
);

    localparam logic [P_SEL-1:0] LP_LAST_SLOT = P_SEL'(3);

    logic [3:0][P_W-1:0] r_shadow;
    logic [3:0][P_W-1:0] r_out;
    logic [P_SEL-1:0]    r_ptr;
    logic                r_frame_done;

    logic                w_accept;
    logic [P_SEL-1:0]    w_slot;
    logic                w_commit;
    logic [3:0][P_W-1:0] w_shadow_next;

    // Handshake: a nibble transfers on a rising edge when in_valid && in_ready.
    // in_ready is low only during reset and clear, so a producer may simply hold
    // in_valid and ent until it sees in_ready high at an edge.
    assign in_ready = rst_n & ~clear;
    assign w_accept = in_valid & in_ready;
    assign w_slot   = auto_mode ? r_ptr : sel;

    // Auto mode commits when the last slot fills; manual mode commits on request.
    always_comb begin
        w_commit = 1'b0;
        if (!clear) begin
            if (auto_mode) begin
                w_commit = w_accept && (r_ptr == LP_LAST_SLOT);
            end else begin
                w_commit = commit;
            end
        end
    end

    // Shadow contents as they will be after this edge; committing from this view
    // lets a same-edge nibble bypass straight into the output frame.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_accept) begin
            w_shadow_next[w_slot] = ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_out        <= '0;
            r_ptr        <= '0;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            r_shadow     <= '0;
            r_out        <= '0;
            r_ptr        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_shadow     <= w_shadow_next;
            r_frame_done <= w_commit;
            if (w_commit) begin
                r_out <= w_shadow_next;
            end
            if (auto_mode && w_accept) begin
                r_ptr <= r_ptr + P_SEL'(1);
            end
        end
    end

    assign out0       = r_out[0];
    assign out1       = r_out[1];
    assign out2       = r_out[2];
    assign out3       = r_out[3];
    assign ptr        = r_ptr;
    assign frame_done = r_frame_done;

endmodule
